// File: rtl/vram_tile_port_if.sv
// Signal bundle between the CPU bus VRAM window / VGA renderer and vram_tile_port.
// master = bus and renderer side, slave = the tile port.
interface vram_tile_port_if;
   logic        sw4VRAM;
   logic        vram_rd;
   logic [3:0]  GPIOvga;
   logic [31:0] Peripheral_in;
   logic [4:0]  data4VRAM;
   logic        vga_req;
   logic [9:0]  vga_col;
   logic [8:0]  vga_row;
   logic [4:0]  vga_tile;
   logic        vga_tile_vld;

   modport master (
      output sw4VRAM, vram_rd, GPIOvga, Peripheral_in, vga_req, vga_col, vga_row,
      input  data4VRAM, vga_tile, vga_tile_vld
   );

   modport slave (
      input  sw4VRAM, vram_rd, GPIOvga, Peripheral_in, vga_req, vga_col, vga_row,
      output data4VRAM, vga_tile, vga_tile_vld
   );
endinterface

// File: rtl/vram_tile_port.sv
// Bomb-Man tile map behind the VRAM bus window: write FIFO, single-port tile RAM, VGA and query read-out.
// Optional: define VRAM_CLEAR_ON_RESET_EN to walk the tile RAM to code 0 after every reset.
module vram_tile_port #(
   parameter int COLS       = 20,
   parameter int ROWS       = 15,
   parameter int FIFO_DEPTH = 4,
   parameter int AW         = 9
) (
   input  logic            clk,
   input  logic            rst,
   vram_tile_port_if.slave bus,
   output logic            wr_overflow,
   output logic            init_busy
);
   localparam int N_TILES = COLS * ROWS;
   localparam int PW      = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0] COLS_A = AW'(COLS);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [4:0]    code;
   } wr_entry_t;

   function automatic logic [AW-1:0] tile_addr(input logic [AW-1:0] ty, input logic [AW-1:0] tx);
      return ty * COLS_A + tx;
   endfunction

   // Bus-side coordinate decode, shared by writes and queries
   logic [4:0]    px, py;
   logic          p_in_range;
   logic [AW-1:0] p_addr;
   logic [4:0]    p_code;
   logic          unused_bits;

   assign px          = bus.Peripheral_in[4:0];
   assign py          = bus.Peripheral_in[12:8];
   assign p_in_range  = (int'(px) < COLS) && (int'(py) < ROWS);
   assign p_addr      = tile_addr(AW'(py), AW'(px));
   assign p_code      = {bus.Peripheral_in[20], bus.GPIOvga};
   assign unused_bits = ^{bus.Peripheral_in[31:21], bus.Peripheral_in[19:13], bus.Peripheral_in[7:5]};

   wr_entry_t     fifo_mem [FIFO_DEPTH];
   logic [4:0]    tile_ram [N_TILES];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   fifo_cnt;
   logic          fifo_empty, fifo_full;

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));

   logic [AW-1:0] qaddr;
   logic          q_pending;
   logic [AW-1:0] clr_addr;
   logic          drain, q_serve, push, ram_we;
   logic [AW-1:0] ram_waddr;
   logic [4:0]    ram_wdata;

   // One RAM access per cycle: clear walk, then VGA, then FIFO drain, then pending query.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      drain     = 1'b0;
      q_serve   = 1'b0;
      ram_we    = 1'b0;
      ram_waddr = fifo_mem[rd_ptr].addr;
      ram_wdata = fifo_mem[rd_ptr].code;
      if (rst) begin
         if (init_busy) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
         end else if (!bus.vga_req) begin
            if (!fifo_empty) begin
               drain  = 1'b1;
               ram_we = 1'b1;
            end else if (q_pending) begin
               q_serve = 1'b1;
            end
         end
      end
   end

   // A full FIFO still accepts when its head leaves in the same cycle.
   assign push = bus.sw4VRAM && p_in_range && (!fifo_full || drain);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_cnt    <= '0;
         wr_overflow <= 1'b0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + PW'(1);
         if (drain) rd_ptr <= rd_ptr + PW'(1);
         if (push && !drain)      fifo_cnt <= fifo_cnt + (PW+1)'(1);
         else if (drain && !push) fifo_cnt <= fifo_cnt - (PW+1)'(1);
         if (bus.sw4VRAM && p_in_range && fifo_full && !drain) wr_overflow <= 1'b1;
      end
   end

   // NOTE: storage arrays carry no reset; pointers and the clear walk define what is valid.
   always_ff @(posedge clk) begin
      if (push)   fifo_mem[wr_ptr]   <= '{addr: p_addr, code: p_code};
      if (ram_we) tile_ram[ram_waddr] <= ram_wdata;
   end

   logic          vga_in_area;
   logic [AW-1:0] vga_addr;

   assign vga_in_area = (bus.vga_col < 10'd640) && (bus.vga_row < 9'd480);
   assign vga_addr    = tile_addr(AW'(bus.vga_row[8:5]), AW'(bus.vga_col[9:5]));

   always_ff @(posedge clk) begin
      if (!rst) begin
         q_pending        <= 1'b0;
         qaddr            <= '0;
         bus.data4VRAM    <= '0;
         bus.vga_tile     <= '0;
         bus.vga_tile_vld <= 1'b0;
      end else begin
         bus.vga_tile_vld <= bus.vga_req;
         if (bus.vga_req)
            bus.vga_tile <= (vga_in_area && !init_busy) ? tile_ram[vga_addr] : '0;
         if (q_serve) begin
            bus.data4VRAM <= tile_ram[qaddr];
            q_pending     <= 1'b0;
         end
         // A fresh query supersedes whatever is still pending.
         if (bus.vram_rd) begin
            if (p_in_range) begin
               qaddr     <= p_addr;
               q_pending <= 1'b1;
            end else begin
               bus.data4VRAM <= '0;
               q_pending     <= 1'b0;
            end
         end
      end
   end

`ifdef VRAM_CLEAR_ON_RESET_EN
   localparam logic [AW-1:0] LAST_A = AW'(N_TILES - 1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         init_busy <= 1'b1;
         clr_addr  <= '0;
      end else if (init_busy) begin
         clr_addr <= clr_addr + AW'(1);
         if (clr_addr == LAST_A) init_busy <= 1'b0;
      end
   end
`else
   assign init_busy = 1'b0;
   assign clr_addr  = '0;
`endif
endmodule

// File: tb/tb_vram_tile_port.sv
// Self-checking bench for vram_tile_port: directed cases plus random traffic against a queue-based model.
module tb_vram_tile_port;
   localparam int COLS = 20;
   localparam int ROWS = 15;
   localparam int NT   = COLS * ROWS;
   localparam int FD   = 4;
`ifdef VRAM_CLEAR_ON_RESET_EN
   localparam bit CLEAR = 1'b1;
`else
   localparam bit CLEAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic wr_overflow, init_busy;

   always #5 clk = ~clk;

   vram_tile_port_if bus ();

   vram_tile_port dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .wr_overflow(wr_overflow),
      .init_busy  (init_busy)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      int cyc;
      int val;
      bit known;
   } exp_t;
   typedef struct {
      int addr;
      int code;
   } wr_t;

   exp_t vga_q[$];
   exp_t qry_q[$];
   wr_t  mfifo[$];
   int   mram[NT];
   bit   mknown[NT];
   bit   m_qpend = 0;
   int   m_qaddr = 0;
   bit   m_ovf   = 0;
   bit   m_init  = CLEAR;
   int   m_clr   = 0;
   int   cyc     = 0;

   task automatic push_qry(input int val, input bit known);
      if (qry_q.size() > 0 && qry_q[$].cyc == cyc) begin
         qry_q[$].val   = val;
         qry_q[$].known = known;
      end else begin
         qry_q.push_back('{cyc: cyc, val: val, known: known});
      end
   endtask

   always @(posedge clk) begin : model
      int  n, x, y, a, va, code;
      bit  busy, drain, serve, in_rng;
      wr_t hd;
      cyc++;
      if (!rst) begin
         mfifo.delete();
         m_qpend = 0;
         m_ovf   = 0;
         m_init  = CLEAR;
         m_clr   = 0;
      end else begin
         busy = m_init;
         n    = mfifo.size();
         if (bus.vga_req) begin
            if (!busy && bus.vga_col < 640 && bus.vga_row < 480) begin
               va = (int'(bus.vga_row) / 32) * COLS + int'(bus.vga_col) / 32;
               vga_q.push_back('{cyc: cyc, val: mram[va], known: mknown[va]});
            end else begin
               vga_q.push_back('{cyc: cyc, val: 0, known: 1'b1});
            end
         end
         drain = !busy && !bus.vga_req && n > 0;
         serve = !busy && !bus.vga_req && n == 0 && m_qpend;
         if (serve) begin
            push_qry(mram[m_qaddr], mknown[m_qaddr]);
            m_qpend = 0;
         end
         if (drain) begin
            hd = mfifo.pop_front();
            mram[hd.addr]   = hd.code;
            mknown[hd.addr] = 1'b1;
         end
         if (busy) begin
            mram[m_clr]   = 0;
            mknown[m_clr] = 1'b1;
            m_clr++;
            if (m_clr == NT) m_init = 0;
         end
         x      = int'(bus.Peripheral_in[4:0]);
         y      = int'(bus.Peripheral_in[12:8]);
         in_rng = (x < COLS) && (y < ROWS);
         a      = y * COLS + x;
         code   = int'(bus.Peripheral_in[20]) * 16 + int'(bus.GPIOvga);
         if (bus.sw4VRAM && in_rng) begin
            if (n < FD || drain) mfifo.push_back('{addr: a, code: code});
            else m_ovf = 1'b1;
         end
         if (bus.vram_rd) begin
            if (in_rng) begin
               m_qaddr = a;
               m_qpend = 1'b1;
            end else begin
               push_qry(0, 1'b1);
               m_qpend = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin : monitor
      bit exp_v;
      exp_v = vga_q.size() > 0 && vga_q[0].cyc == cyc;
      if (exp_v || bus.vga_tile_vld === 1'b1) begin
         check("vga_tile_vld", 32'(bus.vga_tile_vld), 32'(exp_v));
         if (exp_v) begin
            if (vga_q[0].known) check("vga_tile", 32'(bus.vga_tile), vga_q[0].val);
            void'(vga_q.pop_front());
         end
      end
      if (qry_q.size() > 0 && qry_q[0].cyc == cyc) begin
         if (qry_q[0].known) check("data4VRAM", 32'(bus.data4VRAM), qry_q[0].val);
         void'(qry_q.pop_front());
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   function automatic logic [31:0] pin(input int x, input int y, input int attr);
      return {11'b0, 1'(attr), 7'b0, 5'(y), 3'b0, 5'(x)};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_tile(input int x, input int y, input int obj, input int attr);
      bus.sw4VRAM       = 1'b1;
      bus.GPIOvga       = 4'(obj);
      bus.Peripheral_in = pin(x, y, attr);
      @(negedge clk);
      bus.sw4VRAM = 1'b0;
   endtask

   task automatic query(input int x, input int y);
      bus.vram_rd       = 1'b1;
      bus.Peripheral_in = pin(x, y, 0);
      @(negedge clk);
      bus.vram_rd = 1'b0;
   endtask

   task automatic vga_fetch(input int col, input int row);
      bus.vga_req = 1'b1;
      bus.vga_col = 10'(col);
      bus.vga_row = 9'(row);
      @(negedge clk);
      bus.vga_req = 1'b0;
   endtask

   // Release reset and measure how long the clear walk keeps init_busy high.
   task automatic release_reset(input string name);
      int cnt;
      rst = 1'b1;
      cnt = 0;
      while (init_busy === 1'b1 && cnt < 400) begin
         cnt++;
         @(negedge clk);
      end
      check(name, cnt, CLEAR ? NT : 0);
   endtask

   initial begin
      rst               = 1'b0;
      bus.sw4VRAM       = 1'b0;
      bus.vram_rd       = 1'b0;
      bus.GPIOvga       = '0;
      bus.Peripheral_in = '0;
      bus.vga_req       = 1'b0;
      bus.vga_col       = '0;
      bus.vga_row       = '0;
      repeat (3) @(negedge clk);
      check("rst_data4VRAM", 32'(bus.data4VRAM), 0);
      check("rst_vga_tile", 32'(bus.vga_tile), 0);
      check("rst_vga_vld", 32'(bus.vga_tile_vld), 0);
      check("rst_overflow", 32'(wr_overflow), 0);
      check("rst_init_busy", 32'(init_busy), 32'(CLEAR));
      release_reset("init_len_0");

      // Write then read back the same tile.
      write_tile(3, 2, 1, 0);
      query(3, 2);
      idle(2);
      check("wr_rd_3_2", 32'(bus.data4VRAM), 32'h01);

      // VGA hogs the RAM: four writes fit, the fifth overflows.
      bus.vga_req = 1'b1;
      bus.vga_col = 10'd100;
      bus.vga_row = 9'd40;
      for (int i = 0; i < 5; i++) write_tile(i, 7, i + 1, 0);
      check("ovf_set", 32'(wr_overflow), 1);
      bus.vga_req = 1'b0;
      idle(5);
      check("ovf_sticky", 32'(wr_overflow), 1);
      query(3, 7);
      idle(2);
      check("ovf_fourth", 32'(bus.data4VRAM), 32'h04);
      rst = 1'b0;
      @(negedge clk);
      release_reset("init_len_1");
      check("ovf_cleared", 32'(wr_overflow), 0);

      // Bottom-right tile with attribute bit, fetched by VGA.
      write_tile(19, 14, 2, 1);
      idle(2);
      vga_fetch(620, 470);
      check("vga_br_vld", 32'(bus.vga_tile_vld), 1);
      check("vga_br_tile", 32'(bus.vga_tile), 32'h12);
      @(negedge clk);
      check("vga_vld_drop", 32'(bus.vga_tile_vld), 0);
      vga_fetch(640, 10);
      check("vga_off_area", 32'(bus.vga_tile), 0);

      // Out-of-range write must not alias onto (0,1); out-of-range query returns 0.
      write_tile(0, 1, 7, 0);
      write_tile(20, 0, 5, 0);
      idle(2);
      query(19, 14);
      idle(2);
      check("pre_oor", 32'(bus.data4VRAM), 32'h12);
      query(20, 0);
      check("oor_query", 32'(bus.data4VRAM), 0);
      check("oor_no_ovf", 32'(wr_overflow), 0);
      query(0, 1);
      idle(2);
      check("oor_no_alias", 32'(bus.data4VRAM), 32'h07);

      // A query behind a queued write waits and sees the new value.
      write_tile(5, 5, 6, 0);
      idle(2);
      query(5, 5);
      idle(2);
      check("stale_seed", 32'(bus.data4VRAM), 32'h06);
      bus.vga_req = 1'b1;
      write_tile(5, 5, 3, 0);
      query(5, 5);
      idle(3);
      check("query_waits", 32'(bus.data4VRAM), 32'h06);
      bus.vga_req = 1'b0;
      idle(3);
      check("query_fresh", 32'(bus.data4VRAM), 32'h03);

`ifdef VRAM_CLEAR_ON_RESET_EN
      write_tile(0, 0, 1, 0);
      idle(2);
      query(0, 0);
      idle(2);
      check("clr_preload", 32'(bus.data4VRAM), 32'h01);
      rst = 1'b0;
      @(negedge clk);
      release_reset("init_len_2");
      query(0, 0);
      idle(2);
      check("clr_zeroed", 32'(bus.data4VRAM), 0);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         bus.sw4VRAM       = ($urandom_range(0, 2) == 0);
         bus.vram_rd       = ($urandom_range(0, 4) == 0);
         bus.vga_req       = ($urandom_range(0, 1) == 0);
         bus.GPIOvga       = 4'($urandom_range(0, 15));
         bus.Peripheral_in = pin($urandom_range(0, 21), $urandom_range(0, 15), $urandom_range(0, 1));
         bus.vga_col       = 10'($urandom_range(0, 700));
         bus.vga_row       = 9'($urandom_range(0, 511));
         @(negedge clk);
      end
      bus.sw4VRAM = 1'b0;
      bus.vram_rd = 1'b0;
      bus.vga_req = 1'b0;
      idle(10);
      check("rand_ovf", 32'(wr_overflow), 32'(m_ovf));
      check("sb_empty", vga_q.size() + qry_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
